vp_fb_tracker: RTL and testbench

- Closes the value-predictor loop by generating the feedback (validation) interface that the predictor consumes.
- Captures up to two E1-stage predictions per cycle into an in-order outstanding-prediction queue.
- Matches them against in-order execution results and drives fb_pc/fb_actual/fb_mispredict/fb_conf/fb_valid back to the predictor.
- Sits between the predictor's E1 outputs, the execute/writeback stage and the predictor's feedback inputs.

---
 rtl/vp_fb_tracker.sv | 222 ++++++++++++++++++++++
 tb/tb_vp_fb_tracker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_fb_tracker.sv
// Value-predictor feedback tracker: in-order queue of E1 predictions validated against execute results.
// Optional build macro VP_FB_STATS_EN adds saturating pop/mispredict counters.
module vp_fb_tracker #(
    parameter int P_DEPTH    = 16,
    parameter int P_NUM_PRED = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [P_NUM_PRED-1:0][31:1]       pred_pc_e1_i,
    input  logic [P_NUM_PRED-1:0][31:0]       pred_result_e1_i,
    input  logic [P_NUM_PRED-1:0]             pred_conf_e1_i,
    input  logic [P_NUM_PRED-1:0]             pred_valid_e1_i,
    input  logic [P_NUM_PRED-1:0][31:1]       ex_pc_i,
    input  logic [P_NUM_PRED-1:0][31:0]       ex_result_i,
    input  logic [P_NUM_PRED-1:0]             ex_valid_i,
    input  logic                              flush_i,
    output logic [P_NUM_PRED-1:0][31:1]       fb_pc_o,
    output logic [P_NUM_PRED-1:0][31:0]       fb_actual_o,
    output logic [P_NUM_PRED-1:0]             fb_mispredict_o,
    output logic [P_NUM_PRED-1:0]             fb_conf_o,
    output logic [P_NUM_PRED-1:0]             fb_valid_o,
    output logic                              full_o,
    output logic [$clog2(P_DEPTH):0]          count_o,
    output logic                              drop_o,
    output logic                              desync_o
`ifdef VP_FB_STATS_EN
    ,
    output logic [31:0]                       stat_total_o,
    output logic [31:0]                       stat_mispred_o
`endif
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          drop_q, drop_d;
    logic          desync_q, desync_d;

    logic [P_NUM_PRED-1:0][31:1] fb_pc_q, fb_pc_d;
    logic [P_NUM_PRED-1:0][31:0] fb_actual_q, fb_actual_d;
    logic [P_NUM_PRED-1:0]       fb_mispredict_q, fb_mispredict_d;
    logic [P_NUM_PRED-1:0]       fb_conf_q, fb_conf_d;
    logic [P_NUM_PRED-1:0]       fb_valid_q, fb_valid_d;

    logic [31:1] mem_pc_q   [P_DEPTH];
    logic [31:1] mem_pc_d   [P_DEPTH];
    logic [31:0] mem_val_q  [P_DEPTH];
    logic [31:0] mem_val_d  [P_DEPTH];
    logic        mem_conf_q [P_DEPTH];
    logic        mem_conf_d [P_DEPTH];

    logic [P_NUM_PRED-1:0] pop_ok;
    logic                  desync_hit;
    logic                  pop_stop;
    logic [CW-1:0]         n_pop, slot;
    logic [AW-1:0]         rd_idx;

    logic [CW-1:0] n_push, n_acc, free_cnt;
    logic [AW-1:0] wr_off, wr_idx;
    logic          clear, push_ok;

    // Pop side: pair valid ex lanes with head, head+1 using start-of-cycle occupancy only.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        pop_ok          = '0;
        desync_hit      = 1'b0;
        pop_stop        = 1'b0;
        n_pop           = '0;
        slot            = '0;
        rd_idx          = '0;
        fb_pc_d         = fb_pc_q;
        fb_actual_d     = fb_actual_q;
        fb_mispredict_d = fb_mispredict_q;
        fb_conf_d       = fb_conf_q;
        for (int l = 0; l < P_NUM_PRED; l++) begin
            if (ex_valid_i[l] && !flush_i && !pop_stop) begin
                if (slot < count_q) begin
                    rd_idx = head_q + slot[AW-1:0];
                    if (ex_pc_i[l] != mem_pc_q[rd_idx]) begin
                        desync_hit = 1'b1;
                        pop_stop   = 1'b1;
                    end else begin
                        pop_ok[l]          = 1'b1;
                        n_pop              = n_pop + CW'(1);
                        fb_pc_d[l]         = mem_pc_q[rd_idx];
                        fb_actual_d[l]     = ex_result_i[l];
                        fb_mispredict_d[l] = (mem_val_q[rd_idx] != ex_result_i[l]);
                        fb_conf_d[l]       = mem_conf_q[rd_idx];
                    end
                end
                slot = slot + CW'(1);
            end
        end
        fb_valid_d = pop_ok;
    end

    // Push side and queue bookkeeping; a flush or desync empties the queue and swallows pushes.
    always_comb begin
        n_push = '0;
        for (int l = 0; l < P_NUM_PRED; l++) begin
            n_push = n_push + CW'(pred_valid_e1_i[l]);
        end
        free_cnt = CW'(P_DEPTH) - count_q;
        clear    = flush_i | desync_hit;
        push_ok  = !clear && (n_push != '0) && (n_push <= free_cnt);
        drop_d   = !clear && (n_push > free_cnt);
        desync_d = desync_hit;
        n_acc    = push_ok ? n_push : '0;

        mem_pc_d   = mem_pc_q;
        mem_val_d  = mem_val_q;
        mem_conf_d = mem_conf_q;
        wr_off     = '0;
        wr_idx     = '0;
        if (push_ok) begin
            for (int l = 0; l < P_NUM_PRED; l++) begin
                if (pred_valid_e1_i[l]) begin
                    wr_idx             = tail_q + wr_off;
                    mem_pc_d[wr_idx]   = pred_pc_e1_i[l];
                    mem_val_d[wr_idx]  = pred_result_e1_i[l];
                    mem_conf_d[wr_idx] = pred_conf_e1_i[l];
                    wr_off             = wr_off + AW'(1);
                end
            end
        end

        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + n_pop[AW-1:0];
            tail_d  = tail_q + n_acc[AW-1:0];
            count_d = count_q + n_acc - n_pop;
        end
        full_d = (CW'(P_DEPTH) - count_d) < CW'(2);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            full_q          <= 1'b0;
            drop_q          <= 1'b0;
            desync_q        <= 1'b0;
            fb_pc_q         <= '0;
            fb_actual_q     <= '0;
            fb_mispredict_q <= '0;
            fb_conf_q       <= '0;
            fb_valid_q      <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            full_q          <= full_d;
            drop_q          <= drop_d;
            desync_q        <= desync_d;
            fb_pc_q         <= fb_pc_d;
            fb_actual_q     <= fb_actual_d;
            fb_mispredict_q <= fb_mispredict_d;
            fb_conf_q       <= fb_conf_d;
            fb_valid_q      <= fb_valid_d;
        end
    end

    // NOTE: queue storage is not reset; head/tail/count alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        mem_pc_q   <= mem_pc_d;
        mem_val_q  <= mem_val_d;
        mem_conf_q <= mem_conf_d;
    end

    assign fb_pc_o         = fb_pc_q;
    assign fb_actual_o     = fb_actual_q;
    assign fb_mispredict_o = fb_mispredict_q;
    assign fb_conf_o       = fb_conf_q;
    assign fb_valid_o      = fb_valid_q;
    assign full_o          = full_q;
    assign count_o         = count_q;
    assign drop_o          = drop_q;
    assign desync_o        = desync_q;

`ifdef VP_FB_STATS_EN
    logic [31:0]   stat_total_q, stat_total_d;
    logic [31:0]   stat_mispred_q, stat_mispred_d;
    logic [CW-1:0] n_mis;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        n_mis = '0;
        for (int l = 0; l < P_NUM_PRED; l++) begin
            n_mis = n_mis + CW'(pop_ok[l] & fb_mispredict_d[l]);
        end
        stat_total_d   = sat_add(stat_total_q, n_pop);
        stat_mispred_d = sat_add(stat_mispred_q, n_mis);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_total_q   <= '0;
            stat_mispred_q <= '0;
        end else begin
            stat_total_q   <= stat_total_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign stat_total_o   = stat_total_q;
    assign stat_mispred_o = stat_mispred_q;
`endif

endmodule

// File: tb/tb_vp_fb_tracker.sv
// Directed self-checking bench for vp_fb_tracker: expected feedback is queued when pops are driven
// and compared one cycle later when the DUT presents it.
module tb_vp_fb_tracker;

    localparam int P_DEPTH = 16;
    localparam int NP      = 2;
    localparam int CW      = $clog2(P_DEPTH) + 1;

    logic                  clk_i;
    logic                  rst_i;
    logic [NP-1:0][31:1]   pred_pc_e1_i;
    logic [NP-1:0][31:0]   pred_result_e1_i;
    logic [NP-1:0]         pred_conf_e1_i;
    logic [NP-1:0]         pred_valid_e1_i;
    logic [NP-1:0][31:1]   ex_pc_i;
    logic [NP-1:0][31:0]   ex_result_i;
    logic [NP-1:0]         ex_valid_i;
    logic                  flush_i;
    logic [NP-1:0][31:1]   fb_pc_o;
    logic [NP-1:0][31:0]   fb_actual_o;
    logic [NP-1:0]         fb_mispredict_o;
    logic [NP-1:0]         fb_conf_o;
    logic [NP-1:0]         fb_valid_o;
    logic                  full_o;
    logic [CW-1:0]         count_o;
    logic                  drop_o;
    logic                  desync_o;
`ifdef VP_FB_STATS_EN
    logic [31:0]           stat_total_o;
    logic [31:0]           stat_mispred_o;
    int                    exp_total = 0;
    int                    exp_mis   = 0;
`endif

    vp_fb_tracker #(.P_DEPTH(P_DEPTH), .P_NUM_PRED(NP)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .pred_pc_e1_i     (pred_pc_e1_i),
        .pred_result_e1_i (pred_result_e1_i),
        .pred_conf_e1_i   (pred_conf_e1_i),
        .pred_valid_e1_i  (pred_valid_e1_i),
        .ex_pc_i          (ex_pc_i),
        .ex_result_i      (ex_result_i),
        .ex_valid_i       (ex_valid_i),
        .flush_i          (flush_i),
        .fb_pc_o          (fb_pc_o),
        .fb_actual_o      (fb_actual_o),
        .fb_mispredict_o  (fb_mispredict_o),
        .fb_conf_o        (fb_conf_o),
        .fb_valid_o       (fb_valid_o),
        .full_o           (full_o),
        .count_o          (count_o),
        .drop_o           (drop_o),
        .desync_o         (desync_o)
`ifdef VP_FB_STATS_EN
        ,
        .stat_total_o     (stat_total_o),
        .stat_mispred_o   (stat_mispred_o)
`endif
    );

    typedef struct {
        int          lane;
        logic [31:1] pc;
        logic [31:0] actual;
        logic        mis;
        logic        conf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        pred_pc_e1_i     = '0;
        pred_result_e1_i = '0;
        pred_conf_e1_i   = '0;
        pred_valid_e1_i  = '0;
        ex_pc_i          = '0;
        ex_result_i      = '0;
        ex_valid_i       = '0;
        flush_i          = 1'b0;
    endtask

    task automatic drive_push(input int lane, input logic [31:1] pc, input logic [31:0] val,
                              input logic conf);
        pred_valid_e1_i[lane]  = 1'b1;
        pred_pc_e1_i[lane]     = pc;
        pred_result_e1_i[lane] = val;
        pred_conf_e1_i[lane]   = conf;
    endtask

    task automatic drive_ex(input int lane, input logic [31:1] pc, input logic [31:0] res);
        ex_valid_i[lane]  = 1'b1;
        ex_pc_i[lane]     = pc;
        ex_result_i[lane] = res;
    endtask

    // Drive a pop that is expected to match; the bench knows the stored value and confidence.
    task automatic drive_pop(input int lane, input logic [31:1] pc, input logic [31:0] res,
                             input logic [31:0] stored_val, input logic conf);
        exp_t e;
        drive_ex(lane, pc, res);
        e.lane   = lane;
        e.pc     = pc;
        e.actual = res;
        e.mis    = (stored_val != res);
        e.conf   = conf;
        exp_q.push_back(e);
`ifdef VP_FB_STATS_EN
        exp_total++;
        if (e.mis) exp_mis++;
`endif
    endtask

    task automatic tick(input logic exp_drop, input logic exp_desync);
        logic [NP-1:0] mask;
        exp_t          e;
        @(posedge clk_i);
        #1;
        mask = '0;
        foreach (exp_q[i]) mask[exp_q[i].lane] = 1'b1;
        check("fb_valid", 32'(fb_valid_o), 32'(mask));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fb_pc",         32'(fb_pc_o[e.lane]),         32'(e.pc));
            check("fb_actual",     fb_actual_o[e.lane],          e.actual);
            check("fb_mispredict", 32'(fb_mispredict_o[e.lane]), 32'(e.mis));
            check("fb_conf",       32'(fb_conf_o[e.lane]),       32'(e.conf));
        end
        check("drop",   32'(drop_o),   32'(exp_drop));
        check("desync", 32'(desync_o), 32'(exp_desync));
        clear_inputs();
    endtask

    function automatic logic [31:1] fill_pc(input int e);
        return 31'(32'h2E0 + 8 * e);
    endfunction

    function automatic logic [31:1] wrap_pc(input int i);
        return 31'(32'h1000 + 4 * i);
    endfunction

    function automatic logic [31:0] wrap_val(input int i);
        return 32'(i * 3 + 1);
    endfunction

    function automatic logic [31:0] wrap_res(input int i);
        return (i % 5 == 0) ? wrap_val(i) + 32'd1 : wrap_val(i);
    endfunction

    initial begin
        // Reset, with a push held active to show reset wins.
        rst_i = 1'b1;
        clear_inputs();
        drive_push(0, 31'h55, 32'h55, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_count",    32'(count_o),    32'd0);
        check("rst_full",     32'(full_o),     32'd0);
        check("rst_fb_valid", 32'(fb_valid_o), 32'd0);
        check("rst_drop",     32'(drop_o),     32'd0);
        check("rst_desync",   32'(desync_o),   32'd0);
        check("rst_fb_pc0",   32'(fb_pc_o[0]), 32'd0);
        clear_inputs();
        rst_i = 1'b0;

        // Single push, single matching pop.
        drive_push(0, 31'h100, 32'd5, 1'b1);
        tick(1'b0, 1'b0);
        check("count_after_push", 32'(count_o), 32'd1);
        drive_pop(0, 31'h100, 32'd5, 32'd5, 1'b1);
        tick(1'b0, 1'b0);
        check("count_after_pop", 32'(count_o), 32'd0);

        // Dual push, dual pop with a mispredict on lane 1.
        drive_push(0, 31'h200, 32'd7, 1'b0);
        drive_push(1, 31'h204, 32'd9, 1'b1);
        tick(1'b0, 1'b0);
        check("count_dual_push", 32'(count_o), 32'd2);
        drive_pop(0, 31'h200, 32'd7, 32'd7, 1'b0);
        drive_pop(1, 31'h204, 32'd8, 32'd9, 1'b1);
        tick(1'b0, 1'b0);
        check("count_dual_pop", 32'(count_o), 32'd0);

        // Fill to capacity two entries per cycle.
        for (int k = 0; k < P_DEPTH / 2; k++) begin
            drive_push(0, fill_pc(2 * k),     32'h1000 + 32'(2 * k),     1'b0);
            drive_push(1, fill_pc(2 * k + 1), 32'h1000 + 32'(2 * k + 1), 1'b1);
            tick(1'b0, 1'b0);
            check("fill_count", 32'(count_o), 32'(2 * (k + 1)));
            check("fill_full",  32'(full_o),  32'(k == P_DEPTH / 2 - 1));
        end
        drive_push(0, 31'h999, 32'd1, 1'b0);
        drive_push(1, 31'h99D, 32'd2, 1'b0);
        tick(1'b1, 1'b0);
        check("overflow_count", 32'(count_o), 32'd16);
        check("overflow_full",  32'(full_o),  32'd1);

        // Pops at full do not free room for same-cycle pushes.
        drive_pop(0, fill_pc(0), 32'h1000, 32'h1000, 1'b0);
        drive_pop(1, fill_pc(1), 32'h1000, 32'h1001, 1'b1);
        drive_push(0, 31'h777, 32'd3, 1'b0);
        drive_push(1, 31'h77B, 32'd4, 1'b0);
        tick(1'b1, 1'b0);
        check("full_poppush_count", 32'(count_o), 32'd14);
        check("full_poppush_full",  32'(full_o),  32'd0);

        // PC mismatch against head 0x2F0: desync clears queue and swallows the push.
        drive_ex(0, 31'h300, 32'd0);
        drive_push(0, 31'h888, 32'd6, 1'b0);
        tick(1'b0, 1'b1);
        check("desync_count", 32'(count_o), 32'd0);
        tick(1'b0, 1'b0);

        // Flush with simultaneous push and (would-be matching) pop.
        drive_push(0, 31'h600, 32'd1, 1'b0);
        tick(1'b0, 1'b0);
        check("preflush_count", 32'(count_o), 32'd1);
        flush_i = 1'b1;
        drive_push(0, 31'h610, 32'd2, 1'b0);
        drive_push(1, 31'h614, 32'd3, 1'b0);
        drive_ex(0, 31'h600, 32'd1);
        tick(1'b0, 1'b0);
        check("flush_count", 32'(count_o), 32'd0);

        // Lane-1-only push is compacted to the tail; lane 0 pop matches it.
        drive_push(1, 31'h400, 32'h11, 1'b0);
        tick(1'b0, 1'b0);
        check("lane1_push_count", 32'(count_o), 32'd1);
        drive_pop(0, 31'h400, 32'h11, 32'h11, 1'b0);
        tick(1'b0, 1'b0);

        // Lane-1-only pop pairs with the head.
        drive_push(0, 31'h500, 32'h22, 1'b1);
        tick(1'b0, 1'b0);
        drive_pop(1, 31'h500, 32'h23, 32'h22, 1'b1);
        tick(1'b0, 1'b0);

        // Pop from an empty queue is ignored.
        drive_ex(0, 31'h700, 32'd3);
        tick(1'b0, 1'b0);
        check("empty_pop_count", 32'(count_o), 32'd0);

        // Two pops with one entry: second lane is ignored without desync.
        drive_push(0, 31'h800, 32'd4, 1'b1);
        tick(1'b0, 1'b0);
        drive_pop(0, 31'h800, 32'd4, 32'd4, 1'b1);
        drive_ex(1, 31'h804, 32'd0);
        tick(1'b0, 1'b0);
        check("partial_pop_count", 32'(count_o), 32'd0);

        // Wrap: 40 push/pop pairs, pipelined one entry deep.
        drive_push(0, wrap_pc(0), wrap_val(0), 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 1; i < 40; i++) begin
            drive_push(0, wrap_pc(i), wrap_val(i), 1'(i & 1));
            drive_pop(0, wrap_pc(i - 1), wrap_res(i - 1), wrap_val(i - 1), 1'((i - 1) & 1));
            tick(1'b0, 1'b0);
            check("wrap_count", 32'(count_o), 32'd1);
        end
        drive_pop(0, wrap_pc(39), wrap_res(39), wrap_val(39), 1'b1);
        tick(1'b0, 1'b0);
        check("wrap_final_count", 32'(count_o), 32'd0);

`ifdef VP_FB_STATS_EN
        check("stat_total",   stat_total_o,   32'(exp_total));
        check("stat_mispred", stat_mispred_o, 32'(exp_mis));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
